// File: rtl/canasta_pkg.sv
// Shared definitions for the scaled-value scheduler: FSM states, scaling constants, default widths.
package canasta_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StResp = 2'd2
  } state_e;

  // Scaling is x*SCALE_MUL >> SCALE_SHIFT, i.e. floor(x*5/2).
  localparam int unsigned SCALE_MUL   = 5;
  localparam int unsigned SCALE_SHIFT = 1;

  localparam int unsigned DEF_IN_W  = 8;
  localparam int unsigned DEF_OUT_W = 10;

endpackage

// File: rtl/rr_selector.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping around.
module rr_selector #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] sel_o,
  output logic [ID_W-1:0]    sel_id_o,
  output logic               any_o
);

  logic              found;
  logic [ID_W-1:0]   idx;

  // Walk ptr, ptr+1, ... with wrap and keep only the first hit.
  always_comb begin
    sel_o    = '0;
    sel_id_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        sel_o[idx] = 1'b1;
        sel_id_o   = idx;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/convertidor_scheduler.sv
// Shares one floor(x*5/2) scaling datapath among NUM_REQ requesters with round-robin
// arbitration and a valid/ready result handshake tagged with the channel id.
module convertidor_scheduler
  import canasta_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IN_W    = DEF_IN_W,
  parameter int unsigned OUT_W   = DEF_OUT_W,
  parameter int unsigned ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*IN_W-1:0] datoEntrada,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [OUT_W-1:0]        datoSalida,
  output logic [ID_W-1:0]         canal,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic                    busy
);

  // Three extra bits hold x*5 without truncation before the shift.
  localparam int unsigned PROD_W = IN_W + 3;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [IN_W-1:0]      opnd_q, opnd_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [OUT_W-1:0]     res_q, res_d;
  logic [ID_W-1:0]      canal_q, canal_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   sel;
  logic [ID_W-1:0]      sel_id;
  logic                 sel_any;
  logic [IN_W-1:0]      opnd_sel;
  logic [PROD_W-1:0]    prod;
  logic [OUT_W-1:0]     scaled;

  rr_selector #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_selector (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .sel_o    (sel),
    .sel_id_o (sel_id),
    .any_o    (sel_any)
  );

  assign opnd_sel = datoEntrada[32'(sel_id) * IN_W +: IN_W];

  assign prod   = PROD_W'(opnd_q) * PROD_W'(SCALE_MUL);
  assign scaled = OUT_W'(prod >> SCALE_SHIFT);

  // Next-state and registered-output logic; req is only looked at while idle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    opnd_d  = opnd_q;
    gnt_d   = '0;
    res_d   = res_q;
    canal_d = canal_q;
    valid_d = valid_q;
    case (state_q)
      StIdle: begin
        if (sel_any) begin
          opnd_d  = opnd_sel;
          id_d    = sel_id;
          gnt_d   = sel;
          state_d = StCalc;
        end
      end
      StCalc: begin
        res_d   = scaled;
        canal_d = id_q;
        valid_d = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        // valid_out is always high here, so ready_in alone completes the handshake.
        if (ready_in) begin
          valid_d = 1'b0;
          ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset drops any pending result and rewinds the pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      opnd_q  <= '0;
      gnt_q   <= '0;
      res_q   <= '0;
      canal_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      opnd_q  <= opnd_d;
      gnt_q   <= gnt_d;
      res_q   <= res_d;
      canal_q <= canal_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt        = gnt_q;
  assign datoSalida = res_q;
  assign canal      = canal_q;
  assign valid_out  = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_convertidor_scheduler.sv
// Bench for convertidor_scheduler: directed scenarios with literal expectations plus a
// randomized requester population checked every cycle against a transaction-level model.
module tb_convertidor_scheduler;

  localparam int NUM   = 4;
  localparam int IN_W  = 8;
  localparam int OUT_W = 10;
  localparam int ID_W  = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM-1:0]       req = '0;
  logic [NUM*IN_W-1:0]  datoEntrada = '0;
  logic                 ready_in = 1'b1;
  logic [NUM-1:0]       gnt;
  logic [OUT_W-1:0]     datoSalida;
  logic [ID_W-1:0]      canal;
  logic                 valid_out;
  logic                 busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  convertidor_scheduler #(
    .NUM_REQ (NUM),
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .ID_W    (ID_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .datoEntrada (datoEntrada),
    .gnt         (gnt),
    .datoSalida  (datoSalida),
    .canal       (canal),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // First requester at or after p, wrapping; -1 when nobody asks.
  function automatic int pick(input logic [NUM-1:0] r, input int p);
    logic [ID_W-1:0] j;
    for (int k = 0; k < NUM; k++) begin
      j = ID_W'((p + k) % NUM);
      if (r[j]) return int'(j);
    end
    return -1;
  endfunction

  function automatic int opnd_of(input int ch);
    logic [NUM*IN_W-1:0] t;
    t = datoEntrada >> (ch * IN_W);
    return int'(t[IN_W-1:0]);
  endfunction

  function automatic logic [NUM-1:0] onehot(input int ch);
    return NUM'(1) << ch;
  endfunction

  // Transaction timeline: request served -> computed -> presented until consumed.
  int             m_phase = 0;
  int             m_ptr = 0;
  int             m_id = 0;
  int             m_op = 0;
  logic [NUM-1:0] e_gnt = '0;
  int             e_dat = 0;
  int             e_can = 0;
  logic           e_val = 1'b0;
  logic           e_busy = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0;
      m_ptr   <= 0;
      m_id    <= 0;
      m_op    <= 0;
      e_gnt   <= '0;
      e_dat   <= 0;
      e_can   <= 0;
      e_val   <= 1'b0;
      e_busy  <= 1'b0;
    end else begin
      e_gnt <= '0;
      if (m_phase == 0) begin
        if (|req) begin
          m_id    <= pick(req, m_ptr);
          m_op    <= opnd_of(pick(req, m_ptr));
          e_gnt   <= onehot(pick(req, m_ptr));
          m_phase <= 1;
          e_busy  <= 1'b1;
        end
      end else if (m_phase == 1) begin
        e_dat   <= (m_op * 5) / 2;
        e_can   <= m_id;
        e_val   <= 1'b1;
        m_phase <= 2;
      end else if (ready_in) begin
        e_val   <= 1'b0;
        m_ptr   <= (m_id + 1) % NUM;
        m_phase <= 0;
        e_busy  <= 1'b0;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    chk("model_gnt",   32'(gnt),        32'(e_gnt));
    chk("model_valid", 32'(valid_out),  32'(e_val));
    chk("model_busy",  32'(busy),       32'(e_busy));
    chk("model_dat",   32'(datoSalida), e_dat);
    chk("model_canal", 32'(canal),      e_can);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_op(input int ch, input int v);
    datoEntrada[ch*IN_W +: IN_W] = IN_W'(v);
  endtask

  function automatic int rand_op();
    case ($urandom % 8)
      0: return 0;
      1: return 1;
      2: return 254;
      3: return 255;
      default: return int'($urandom % 256);
    endcase
  endfunction

  int corner_in[5]  = '{0, 1, 3, 254, 255};
  int corner_out[5] = '{0, 2, 7, 635, 637};

  initial begin
    // 1: reset with all requests pending
    reset = 1'b1;
    req = 4'b1111;
    ready_in = 1'b1;
    tick();
    tick();
    chk("rst_gnt",   32'(gnt), 0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_dat",   32'(datoSalida), 0);
    chk("rst_canal", 32'(canal), 0);
    reset = 1'b0;
    tick();
    chk("rst_first_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();
    tick();

    // 2: single request on channel 2
    set_op(2, 200);
    req = 4'b0100;
    tick();
    chk("single_gnt", 32'(gnt), 32'h4);
    req = '0;
    tick();
    chk("single_gnt_off", 32'(gnt), 0);
    chk("single_valid",   32'(valid_out), 1);
    chk("single_dat",     32'(datoSalida), 500);
    chk("single_canal",   32'(canal), 2);
    tick();
    chk("single_valid_off", 32'(valid_out), 0);

    // 3: arithmetic corners through channel 1
    for (int i = 0; i < 5; i++) begin
      set_op(1, corner_in[i]);
      req = 4'b0010;
      tick();
      req = '0;
      tick();
      chk("corner_dat", 32'(datoSalida), corner_out[i]);
      tick();
    end

    // 4: fairness with every requester re-raising after service
    reset = 1'b1;
    for (int c = 0; c < NUM; c++) set_op(c, 10 * (c + 1));
    req = 4'b1111;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("fair_gnt", 32'(gnt), 32'(onehot(i % NUM)));
      req[i % NUM] = 1'b0;
      tick();
      chk("fair_canal", 32'(canal), i % NUM);
      chk("fair_dat",   32'(datoSalida), (10 * (i % NUM + 1) * 5) / 2);
      tick();
      req[i % NUM] = 1'b1;
    end
    req = '0;
    tick();

    // 5: backpressure while operands and requests move underneath
    ready_in = 1'b0;
    set_op(3, 100);
    req = 4'b1000;
    tick();
    chk("bp_gnt", 32'(gnt), 32'h8);
    req = '0;
    set_op(3, 7);
    tick();
    set_op(0, 50);
    req[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(valid_out), 1);
      chk("bp_dat",   32'(datoSalida), 250);
      chk("bp_canal", 32'(canal), 3);
      chk("bp_gnt_held", 32'(gnt), 0);
      set_op(1, int'($urandom % 256));
      set_op(3, int'($urandom % 256));
      tick();
    end
    ready_in = 1'b1;
    tick();
    chk("bp_release_valid", 32'(valid_out), 0);
    tick();
    chk("bp_next_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();
    chk("bp_next_dat", 32'(datoSalida), 125);
    tick();

    // 6: asynchronous reset while presenting a result
    ready_in = 1'b0;
    set_op(2, 9);
    req = 4'b0100;
    tick();
    req = '0;
    tick();
    chk("ar_valid_before", 32'(valid_out), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid_async", 32'(valid_out), 0);
    chk("ar_busy_async",  32'(busy), 0);
    tick();
    req = 4'b0101;
    tick();
    reset = 1'b0;
    ready_in = 1'b1;
    tick();
    chk("ar_gnt_ch0", 32'(gnt), 32'h1);
    req = 4'b0100;
    tick();
    tick();
    tick();
    chk("ar_gnt_ch2", 32'(gnt), 32'h4);
    req = '0;
    tick();
    tick();

    // Randomized requesters obeying the request protocol
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int i = 0; i < NUM; i++) begin
        if (req[i] && gnt[i]) begin
          req[i] = 1'b0;
          if ($urandom % 2 == 0) set_op(i, rand_op());
        end else if (!req[i]) begin
          if ($urandom % 4 == 0) begin
            set_op(i, rand_op());
            req[i] = 1'b1;
          end else if ($urandom % 2 == 0) begin
            set_op(i, rand_op());
          end
        end
      end
      ready_in = ($urandom % 4 != 0);
      reset = ($urandom % 250 == 0);
    end
    reset = 1'b0;
    req = '0;
    ready_in = 1'b1;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
